// File: rtl/dcsk_demod.sv
// DCSK demodulator: frames the incoming chip stream into reference/data
// halves, correlates each data chip against its stored reference chip,
// decides one bit per spreading period and packs 32 bits into a word.
module dcsk_demod #(
   parameter int WORD_W = 32,
   parameter int MAX_SF = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              In_Mod_Data,
   input  logic              Valid,
   input  logic [1:0]        Spread_Factor_Sel,
   output logic [WORD_W-1:0] Out_Data,
   output logic              Valid_Data
);
   localparam int CW = $clog2(MAX_SF);     // chip index width
   localparam int RD = MAX_SF / 2;         // reference buffer depth
   localparam int RW = $clog2(RD);         // reference index width
   localparam int BW = $clog2(WORD_W);     // bit index width

   logic [CW-1:0]      r_chip_cnt;
   logic [BW-1:0]      r_bit_cnt;
   logic [1:0]         r_sf_sel;
   logic [RD-1:0]      r_ref;
   logic signed [6:0]  r_acc;
   logic [WORD_W-1:0]  r_word;

   logic               w_word_start;
   logic               w_is_ref;
   logic               w_last_chip;
   logic               w_last_bit;
   logic               w_match;
   logic               w_bit;
   logic [1:0]         w_sf_sel;
   logic [CW-1:0]      w_half;
   logic [CW-1:0]      w_last_idx;
   logic [CW-1:0]      w_data_off;
   logic [RW-1:0]      w_ref_wr_idx;
   logic [RW-1:0]      w_ref_rd_idx;
   logic signed [6:0]  w_acc_next;
   logic [WORD_W-1:0]  w_word_next;

   // Framing, correlation step and bit decision for the chip on the input
   always_comb begin
      // The spreading factor is taken live on the very first chip of a word
      // (it is latched on that same edge) and from the latch afterwards.
      w_word_start = (r_bit_cnt == '0) && (r_chip_cnt == '0);
      w_sf_sel     = w_word_start ? Spread_Factor_Sel : r_sf_sel;
      w_half       = CW'(2);
      w_last_idx   = CW'(3);
      case (w_sf_sel)
         2'b00: begin w_half = CW'(2);  w_last_idx = CW'(3);  end
         2'b01: begin w_half = CW'(4);  w_last_idx = CW'(7);  end
         2'b10: begin w_half = CW'(8);  w_last_idx = CW'(15); end
         default: begin w_half = CW'(16); w_last_idx = CW'(31); end
      endcase
      w_is_ref     = (r_chip_cnt < w_half);
      w_data_off   = r_chip_cnt - w_half;
      w_ref_wr_idx = r_chip_cnt[RW-1:0];
      w_ref_rd_idx = w_data_off[RW-1:0];
      w_match      = ~(In_Mod_Data ^ r_ref[w_ref_rd_idx]);
      w_acc_next   = w_match ? (r_acc + 7'sd1) : (r_acc - 7'sd1);
      w_last_chip  = (r_chip_cnt == w_last_idx);
      w_last_bit   = (r_bit_cnt == BW'(WORD_W - 1));
      // Non-negative correlation (including a tie) decides a 1
      w_bit        = ~w_acc_next[6];
      w_word_next  = {r_word[WORD_W-2:0], w_bit};
   end

   // Counters, reference buffer, accumulator and word output; Valid=0 freezes all
   always_ff @(posedge Clk) begin
      Valid_Data <= 1'b0;
      if (Rst) begin
         r_chip_cnt <= '0;
         r_bit_cnt  <= '0;
         r_sf_sel   <= '0;
         r_ref      <= '0;
         r_acc      <= '0;
         r_word     <= '0;
         Out_Data   <= '0;
      end else if (Valid) begin
         if (w_word_start) begin
            r_sf_sel <= Spread_Factor_Sel;
         end
         if (w_is_ref) begin
            r_ref[w_ref_wr_idx] <= In_Mod_Data;
            if (r_chip_cnt == '0) begin
               r_acc <= '0;
            end
         end else begin
            r_acc <= w_acc_next;
         end
         if (w_last_chip) begin
            r_chip_cnt <= '0;
            if (w_last_bit) begin
               r_bit_cnt  <= '0;
               r_word     <= '0;
               Out_Data   <= w_word_next;
               Valid_Data <= 1'b1;
            end else begin
               r_bit_cnt <= r_bit_cnt + BW'(1);
               r_word    <= w_word_next;
            end
         end else begin
            r_chip_cnt <= r_chip_cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_dcsk_demod.sv
// Testbench for dcsk_demod: random chip streams built from the DCSK rules,
// expected words queued on issue and checked by an independent monitor.
module tb_dcsk_demod;
   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        In_Mod_Data = 1'b0;
   logic        Valid = 1'b0;
   logic [1:0]  Spread_Factor_Sel = 2'b00;
   logic [31:0] Out_Data;
   logic        Valid_Data;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] w;
      time         t;
   } exp_t;
   exp_t        sb[$];
   logic [31:0] last_exp = '0;

   dcsk_demod #(.WORD_W(32), .MAX_SF(32)) dut (
      .Clk               (Clk),
      .Rst               (Rst),
      .In_Mod_Data       (In_Mod_Data),
      .Valid             (Valid),
      .Spread_Factor_Sel (Spread_Factor_Sel),
      .Out_Data          (Out_Data),
      .Valid_Data        (Valid_Data)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Monitor: every strobe must match the head of the scoreboard and arrive
   // one clock after the final chip; an overdue entry counts as a missed strobe.
   always @(negedge Clk) begin
      exp_t e;
      if (Valid_Data) begin
         if (sb.size() == 0) begin
            check("unexpected_strobe", 32'(Valid_Data), 32'd0);
         end else begin
            e = sb.pop_front();
            check("word", Out_Data, e.w);
            check("latency", 32'($time - e.t), 32'd4);
         end
      end else if (sb.size() != 0 && ($time - sb[0].t) > 4) begin
         e = sb.pop_front();
         check("strobe_timeout", 32'(Valid_Data), 32'd1);
      end
   end

   task automatic gap(input int n);
      Valid = 1'b0;
      repeat (n) begin
         In_Mod_Data = 1'($urandom_range(0, 1));
         @(posedge Clk); #1;
      end
   endtask

   task automatic drive_chip(input logic d, input bit gaps);
      if (gaps && $urandom_range(0, 15) == 0) gap($urandom_range(1, 9));
      In_Mod_Data = d;
      Valid       = 1'b1;
      @(posedge Clk); #1;
   endtask

   // ref_mode 1: reference chips 1,0,1,0...; otherwise random.
   // noise flips random data chips; expected bit is the sign of the
   // correlation sum, with a zero sum deciding 1.
   // stop_after > 0 abandons the word after that many chips (nothing expected).
   task automatic send_word(input logic [31:0] w, input logic [1:0] sel, input int ref_mode,
                            input bit gaps, input bit toggle, input bit noise, input int stop_after);
      int          half;
      int          sent;
      int          sum;
      logic        bitv;
      logic        d;
      logic [31:0] exp_w;
      logic        ref_chips [16];
      half  = (4 << sel) / 2;
      sent  = 0;
      exp_w = '0;
      for (int b = 0; b < 32; b++) begin
         bitv = w[31-b];
         sum  = 0;
         for (int c = 0; c < half; c++) begin
            ref_chips[c] = (ref_mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            if (b == 0 && c == 0) Spread_Factor_Sel = sel;
            else if (toggle && $urandom_range(0, 7) == 0) Spread_Factor_Sel = 2'($urandom_range(0, 3));
            if (stop_after > 0 && sent >= stop_after) return;
            drive_chip(ref_chips[c], gaps);
            sent++;
         end
         if (gaps && b == 0) gap($urandom_range(1, 9));
         for (int c = 0; c < half; c++) begin
            d = bitv ? ref_chips[c] : ~ref_chips[c];
            if (noise && $urandom_range(0, 3) == 0) d = ~d;
            sum += (d == ref_chips[c]) ? 1 : -1;
            if (toggle && $urandom_range(0, 7) == 0) Spread_Factor_Sel = 2'($urandom_range(0, 3));
            if (stop_after > 0 && sent >= stop_after) return;
            drive_chip(d, gaps);
            sent++;
         end
         exp_w = {exp_w[30:0], (sum >= 0)};
      end
      last_exp = exp_w;
      sb.push_back('{exp_w, $time});
   endtask

   initial begin
      // Reset for two cycles, then idle
      @(posedge Clk);
      @(negedge Clk);
      check("rst_out_data", Out_Data, 32'd0);
      check("rst_valid_data", 32'(Valid_Data), 32'd0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         check("idle_out_data", Out_Data, 32'd0);
         check("idle_valid_data", 32'(Valid_Data), 32'd0);
      end
      @(posedge Clk); #1;

      // SF4, contiguous, 1,0 reference pattern
      send_word(32'hA5A5_0F0F, 2'b00, 1, 1'b0, 1'b0, 1'b0, 0);
      gap(4);
      check("hold_sf4", Out_Data, 32'hA5A5_0F0F);

      // SF32, random references
      send_word(32'hFFFF_0000, 2'b11, 0, 1'b0, 1'b0, 1'b0, 0);
      gap(3);

      // SF8 with random Valid gaps, including between reference and data halves
      send_word(32'h1234_5678, 2'b01, 0, 1'b1, 1'b0, 1'b0, 0);
      gap(3);

      // Back-to-back words, SF toggled mid-word in the first
      send_word(32'hDEAD_BEEF, 2'b10, 0, 1'b0, 1'b1, 1'b0, 0);
      send_word(32'h0000_0001, 2'b00, 0, 1'b0, 1'b0, 1'b0, 0);
      gap(3);
      check("hold_b2b", Out_Data, 32'h0000_0001);

      // Reset after 100 chips of an SF8 word, then a full word
      send_word(32'h5555_AAAA, 2'b01, 0, 1'b0, 1'b0, 1'b0, 100);
      Rst = 1'b1;
      @(posedge Clk); #1;
      Rst   = 1'b0;
      Valid = 1'b0;
      @(negedge Clk);
      check("midword_rst_out_data", Out_Data, 32'd0);
      check("midword_rst_valid_data", 32'(Valid_Data), 32'd0);
      send_word(32'hCAFE_F00D, 2'b01, 0, 1'b0, 1'b0, 1'b0, 0);
      gap(3);

      // Noisy SF4 word: single flips give zero-sum ties that must decide 1
      send_word($urandom, 2'b00, 0, 1'b0, 1'b0, 1'b1, 0);
      // Random words: random SF, gaps, noise and mid-word SF changes
      for (int i = 0; i < 4; i++) begin
         send_word($urandom, 2'($urandom_range(0, 3)), 0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 0);
      end
      gap(6);
      check("final_hold", Out_Data, last_exp);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dcsk_demod.md
Name: dcsk_demod

Overview:
- Digital DCSK (differential chaos shift keying) demodulator on the receive side of the modem.
- Consumes the serial chip stream from the transmitter, one chip per clock while the transmitter qualifies it, and recovers one bit per spreading period.
- Correlates the data half of each bit period against the stored reference half.
- Assembles recovered bits into 32-bit words and pulses a valid strobe per completed word.

Parameters:
- WORD_W, 32, bits per recovered word
- MAX_SF, 32, largest spreading factor (chips per bit); reference buffer depth is MAX_SF/2

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Rst  in  1  synchronous, active-high reset
- In_Mod_Data  in  1  modulated chip; 1 = +1, 0 = -1
- Valid  in  1  chip qualifier; In_Mod_Data sampled only when 1
- Spread_Factor_Sel  in  2  00=SF4, 01=SF8, 10=SF16, 11=SF32
- Out_Data  out  WORD_W  last fully recovered word
- Valid_Data  out  1  one-cycle strobe, Out_Data newly updated

Behaviour:
- One clock domain, Clk. Reset is synchronous and active-high (Rst).
- Rst=1 at a clock edge clears the following:
  - Out_Data=0 and Valid_Data=0.
  - Chip counter, bit counter, reference buffer, accumulator and latched SF.
  - Any partial word is discarded.
  - Rst overrides Valid.
- Chip framing per bit, with SF chips:
  - Chips 0..SF/2-1 are the reference; shift them into the reference buffer.
  - Chips SF/2..SF-1 are data.
  - Data chip k is compared with reference chip k-SF/2.
  - Transmitted bit 1 sends the data half equal to the reference; bit 0 sends it inverted.
- Correlation:
  - Signed accumulator, 7 bits minimum, cleared at each bit start.
  - Each data chip adds +1 on match (XNOR=1) and -1 on mismatch.
  - Decision after the last data chip: accumulator >= 0 gives bit 1, < 0 gives bit 0. A tie (0) therefore decides 1.
- Word assembly:
  - Bits are shifted in MSB first; the first recovered bit is word bit 31.
  - After the 32nd bit, Out_Data <= the assembled word on the same edge that samples the last data chip. Valid_Data=1 for exactly that following cycle.
  - Latency: Valid_Data rises 1 clock after the final chip is presented.
- SF latching:
  - Spread_Factor_Sel is captured on the first valid chip of a word (bit 0, chip 0) and held for all 32 bits.
  - Changes mid-word are ignored. Each new word may use a different SF.
- Valid handling:
  - Valid=0 pauses all counters, buffer and accumulator; state is retained.
  - Framing resumes on the next Valid=1 chip.
  - Bursts with gaps of any length do not realign framing.
- Back-to-back words:
  - The next word's chip 0 may arrive the cycle after the previous word's last chip.
  - No dead cycle is required.
  - Valid_Data still deasserts after one cycle.
- Out_Data holds its value until the next word completes or reset.
- Word length in chips = 32*SF, so 128 chips minimum at SF4. Consecutive Valid_Data pulses are therefore never adjacent.
- No error or overflow outputs. Accumulator range is ±16, so no saturation logic is needed.

Test Plan:
- Rst=1 for 2 cycles, then idle with Valid=0 -> Out_Data=0, Valid_Data=0 throughout.
- SF4: send 0xA5A5_0F0F as 128 contiguous chips, reference pattern 1,0 per bit -> Out_Data=0xA5A50F0F and Valid_Data=1 for one cycle, 1 clock after the last chip.
- SF32: send 0xFFFF_0000 with random 16-chip references -> Out_Data=0xFFFF0000 after 1024 chips.
- Burst gaps: send 0x1234_5678 at SF8 with Valid=0 inserted for 1..9 cycles at random points, including mid-bit and between reference and data halves -> Out_Data=0x12345678, exactly one strobe.
- Back-to-back words, SF changed between them: 0xDEAD_BEEF at SF16 then 0x0000_0001 at SF4. Spread_Factor_Sel is toggled mid-word during the first word -> two strobes with correct values; the mid-word SF change has no effect.
- Rst asserted mid-word at SF8 (after 100 chips), then a full word 0xCAFE_F00D -> the partial word is discarded and only 0xCAFEF00D is reported.
